// File: rtl/bldc_pwm_commutator.sv
// Three-phase BLDC gate driver: counter-compare PWM, filtered Hall
// commutation, per-switch dead time, invalid-Hall fault, period capture.
module bldc_pwm_commutator #(
    parameter int PWM_W     = 8,
    parameter int DT_W      = 4,
    parameter int HALL_FILT = 3,
    parameter int PER_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_en,
    input  logic [PWM_W-1:0] duty,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             dir,
    input  logic [2:0]       hall,
    output logic             pwm_out,
    output logic             AP,
    output logic             BP,
    output logic             CP,
    output logic             AN,
    output logic             BN,
    output logic             CN,
    output logic             fault,
    output logic [PER_W-1:0] comm_period,
    output logic             comm_stb
);

    localparam int FW = $clog2(HALL_FILT + 1);
    localparam logic [FW-1:0]    FILT_N  = FW'(HALL_FILT);
    localparam logic [PWM_W-1:0] CNT_MAX = '1;
    localparam logic [PER_W-1:0] PER_MAX = '1;

    localparam logic [1:0] R_F = 2'd0;
    localparam logic [1:0] R_H = 2'd1;
    localparam logic [1:0] R_L = 2'd2;

    // PWM state
    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] duty_sh_q, duty_sh_d;
    logic             en_prev_q;
    logic             pwm_q, pwm_d;

    // Hall path state
    logic [2:0]    s1_q, s2_q;
    logic [2:0]    cand_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [2:0]    hall_q, hall_d;
    logic          accept;
    logic          valid_new;
    logic          comm_acc;
    logic          fault_set;

    // Period / fault state
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] period_q;
    logic             stb_q;
    logic             fault_q;

    // Phase roles and switch requests (0..2 = A,B,C high side, 3..5 low side)
    logic [1:0]            role [3];
    logic                  gate_en;
    logic [5:0]            sw_req;
    logic [5:0][DT_W-1:0]  dt_q;
    logic [5:0]            gate_q;

    // PWM counter, duty shadow and compare
    always_comb begin
        cnt_d     = '0;
        duty_sh_d = duty_sh_q;
        pwm_d     = 1'b0;
        if (pwm_en) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX || !en_prev_q) begin
                duty_sh_d = duty;
            end
            pwm_d = duty_sh_q > cnt_q;
        end
    end

    // PWM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            duty_sh_q <= '0;
            en_prev_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            duty_sh_q <= duty_sh_d;
            en_prev_q <= pwm_en;
            pwm_q     <= pwm_d;
        end
    end

    // Hall filter: accept a code after HALL_FILT matching synchronized samples
    always_comb begin
        if (s2_q == cand_q) begin
            fcnt_d = (fcnt_q == FILT_N) ? fcnt_q : fcnt_q + 1'b1;
        end else begin
            fcnt_d = FW'(1);
        end
        accept    = (fcnt_d == FILT_N);
        hall_d    = accept ? s2_q : hall_q;
        valid_new = (s2_q != 3'b000) && (s2_q != 3'b111);
        comm_acc  = accept && (s2_q != hall_q) && valid_new;
        fault_set = accept && (s2_q != hall_q) && !valid_new && pwm_en;
        if (comm_acc) begin
            per_d = PER_W'(1);
        end else begin
            per_d = (per_q == PER_MAX) ? per_q : per_q + 1'b1;
        end
    end

    // Hall synchronizer, filter, period capture and sticky fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 3'b000;
            s2_q     <= 3'b000;
            cand_q   <= 3'b000;
            fcnt_q   <= '0;
            hall_q   <= 3'b000;
            per_q    <= '0;
            period_q <= '0;
            stb_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            s1_q   <= hall;
            s2_q   <= s1_q;
            cand_q <= s2_q;
            fcnt_q <= fcnt_d;
            hall_q <= hall_d;
            per_q  <= per_d;
            stb_q  <= comm_acc;
            if (comm_acc) begin
                period_q <= per_q;
            end
            if (!pwm_en) begin
                fault_q <= 1'b0;
            end else if (fault_set) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Forward role table; invalid codes float every phase
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            role[i] = R_F;
        end
        unique case (hall_q)
            3'b001: begin role[0] = R_F; role[1] = R_L; role[2] = R_H; end
            3'b010: begin role[0] = R_L; role[1] = R_H; role[2] = R_F; end
            3'b100: begin role[0] = R_H; role[1] = R_F; role[2] = R_L; end
            3'b011: begin role[0] = R_L; role[1] = R_F; role[2] = R_H; end
            3'b101: begin role[0] = R_H; role[1] = R_L; role[2] = R_F; end
            3'b110: begin role[0] = R_F; role[1] = R_H; role[2] = R_L; end
            default: ;
        endcase
    end

    // Switch requests; reverse direction swaps high and low roles
    always_comb begin
        gate_en = pwm_en && !fault_q && pwm_q;
        sw_req  = '0;
        for (int i = 0; i < 3; i++) begin
            sw_req[i]   = gate_en && (role[i] == (dir ? R_L : R_H));
            sw_req[i+3] = gate_en && (role[i] == (dir ? R_H : R_L));
        end
    end

    // Dead time: off immediately, on after dead_time steady request cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dt_q   <= '0;
            gate_q <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!sw_req[i]) begin
                    dt_q[i]   <= '0;
                    gate_q[i] <= 1'b0;
                end else if (dt_q[i] >= dead_time) begin
                    gate_q[i] <= 1'b1;
                end else begin
                    dt_q[i] <= dt_q[i] + 1'b1;
                end
            end
        end
    end

    assign pwm_out     = pwm_q;
    assign AP          = ~gate_q[0];
    assign BP          = ~gate_q[1];
    assign CP          = ~gate_q[2];
    assign AN          = gate_q[3];
    assign BN          = gate_q[4];
    assign CN          = gate_q[5];
    assign fault       = fault_q;
    assign comm_period = period_q;
    assign comm_stb    = stb_q;

endmodule

// File: tb/tb_bldc_pwm_commutator.sv
// Bench for bldc_pwm_commutator: commutation scoreboard plus directed
// PWM, role, dead-time, glitch, fault and reset vectors.
module tb_bldc_pwm_commutator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm_en;
    logic [7:0]  duty;
    logic [3:0]  dead_time;
    logic        dir;
    logic [2:0]  hall;
    logic        pwm_out;
    logic        AP, BP, CP, AN, BN, CN;
    logic        fault;
    logic [15:0] comm_period;
    logic        comm_stb;

    typedef struct {
        bit          chk;
        int unsigned per;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    bldc_pwm_commutator #(
        .PWM_W(8), .DT_W(4), .HALL_FILT(3), .PER_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwm_en(pwm_en), .duty(duty),
        .dead_time(dead_time), .dir(dir), .hall(hall),
        .pwm_out(pwm_out), .AP(AP), .BP(BP), .CP(CP),
        .AN(AN), .BN(BN), .CN(CN), .fault(fault),
        .comm_period(comm_period), .comm_stb(comm_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit c, input int unsigned p);
        exp_t e;
        e.chk = c;
        e.per = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_pwm(input logic lvl, input string nm);
        int k = 0;
        while (pwm_out !== lvl && k < 600) begin
            tick(1);
            k++;
        end
        check(nm, pwm_out, lvl);
    endtask

    // Monitor: commutation strobes against the scoreboard, shoot-through
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (comm_stb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("comm_stb_unexpected", comm_stb, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.chk) check("comm_period", comm_period, mon_e.per);
                end
            end
            check("shoot_through",
                  (!AP && AN) || (!BP && BN) || (!CP && CN), 0);
        end
    end

    // One Hall step with exact 1000-cycle dwell; roles = effective A,B,C
    task automatic do_step(input logic [2:0] code, input logic d,
                           input string roles, input bit chk);
        int p_on[3];
        int n_on[3];
        hall = code;
        dir  = d;
        push(chk, 1000);
        tick(20);
        for (int i = 0; i < 3; i++) begin
            p_on[i] = 0;
            n_on[i] = 0;
        end
        for (int c = 0; c < 256; c++) begin
            tick(1);
            p_on[0] += (AP == 1'b0); p_on[1] += (BP == 1'b0); p_on[2] += (CP == 1'b0);
            n_on[0] += (AN == 1'b1); n_on[1] += (BN == 1'b1); n_on[2] += (CN == 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("role_%b_d%0d_ph%0d_P", code, d, i), p_on[i],
                  (roles.substr(i, i) == "H") ? 64 : 0);
            check($sformatf("role_%b_d%0d_ph%0d_N", code, d, i), n_on[i],
                  (roles.substr(i, i) == "L") ? 64 : 0);
        end
        tick(724);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, cp_lo, bn_hi, ap_lo, an_hi, bad_ap, bad_bn, stbs, k;
        rst_n = 1'b0; pwm_en = 1'b0; duty = 8'd0; dead_time = 4'd0;
        dir = 1'b0; hall = 3'b001;
        tick(3);
        check("rst_pwm_out", pwm_out, 0);
        check("rst_gates", {AP, BP, CP, AN, BN, CN}, 6'b111000);
        check("rst_fault", fault, 0);
        check("rst_comm_period", comm_period, 0);
        check("rst_comm_stb", comm_stb, 0);

        // Release: hall_q 000 -> 001 is an accepted commutation
        push(0, 0);
        rst_n = 1'b1;
        tick(20);

        // Duty 64, dead time 0, hall 001: C high side, B low side
        duty = 8'd64; pwm_en = 1'b1;
        tick(600);
        hi = 0; cp_lo = 0; bn_hi = 0; ap_lo = 0; an_hi = 0;
        for (int c = 0; c < 512; c++) begin
            tick(1);
            hi += pwm_out; cp_lo += !CP; bn_hi += BN; ap_lo += !AP; an_hi += AN;
        end
        check("pwm_high_64", hi, 128);
        check("cp_low_64", cp_lo, 128);
        check("bn_high_64", bn_hi, 128);
        check("ap_never_on", ap_lo, 0);
        check("an_never_on", an_hi, 0);

        // Forward sweep, then reverse sweep (H/L swapped)
        do_step(3'b011, 0, "LFH", 0);
        do_step(3'b010, 0, "LHF", 1);
        do_step(3'b110, 0, "FHL", 1);
        do_step(3'b100, 0, "HFL", 1);
        do_step(3'b101, 0, "HLF", 1);
        do_step(3'b001, 1, "FHL", 1);
        do_step(3'b011, 1, "HFL", 1);
        do_step(3'b010, 1, "HLF", 1);
        do_step(3'b110, 1, "FLH", 1);
        do_step(3'b100, 1, "LFH", 1);
        do_step(3'b101, 1, "LHF", 1);

        // Dead time 5, duty 255: 001 -> 101
        dead_time = 4'd5; duty = 8'd255; dir = 1'b0; hall = 3'b001;
        push(0, 0);
        tick(600);
        wait_pwm(1'b0, "dt_pwm_low_seen");
        tick(40);
        hall = 3'b101;
        push(0, 0);
        k = 0;
        while (comm_stb !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("dt_stb_seen", comm_stb, 1);
        check("dt_cp_before", CP, 0);
        check("dt_ap_before", AP, 1);
        tick(1);
        check("dt_cp_off", CP, 1);
        tick(4);
        check("dt_ap_early", AP, 1);
        tick(1);
        check("dt_ap_on", AP, 0);
        check("dt_bn_held", BN, 1);

        // Two-sample glitch to 011 must be ignored
        wait_pwm(1'b0, "gl_pwm_low_seen");
        tick(20);
        hall = 3'b011;
        tick(2);
        hall = 3'b101;
        bad_ap = 0; bad_bn = 0; stbs = 0;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            bad_ap += (AP !== 1'b0); bad_bn += (BN !== 1'b1); stbs += comm_stb;
        end
        check("gl_ap_steady", bad_ap, 0);
        check("gl_bn_steady", bad_bn, 0);
        check("gl_no_stb", stbs, 0);

        // Invalid Hall fault, sticky until pwm_en drops
        hall = 3'b111;
        tick(10);
        check("fault_set", fault, 1);
        check("fault_gates_off", {AP, BP, CP, AN, BN, CN}, 6'b111000);
        hall = 3'b101;
        push(0, 0);
        tick(20);
        check("fault_sticky", fault, 1);
        check("fault_sticky_gates", {AP, BP, CP, AN, BN, CN}, 6'b111000);
        duty = 8'd64; dead_time = 4'd0; pwm_en = 1'b0;
        tick(1);
        pwm_en = 1'b1;
        tick(1);
        check("fault_cleared", fault, 0);

        // Duty change mid-period only applies after the wrap
        wait_pwm(1'b1, "dr_pwm_high_seen");
        wait_pwm(1'b0, "dr_pwm_fall_seen");
        tick(35);
        duty = 8'd200;
        hi = 0;
        for (int c = 0; c < 150; c++) begin
            tick(1);
            hi += pwm_out;
        end
        check("dr_old_duty_holds", hi, 0);
        tick(6);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            tick(1);
            hi += pwm_out;
        end
        check("dr_new_duty_200", hi, 200);

        // Asynchronous reset mid-period
        tick(50);
        check("pre_rst_gates", {AP, BP, CP, AN, BN, CN}, 6'b011010);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm_out", pwm_out, 0);
        check("arst_gates", {AP, BP, CP, AN, BN, CN}, 6'b111000);
        check("arst_fault", fault, 0);
        check("arst_comm_period", comm_period, 0);
        check("arst_comm_stb", comm_stb, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bldc_pwm_commutator.md
# bldc_pwm_commutator

Parametrised three-phase BLDC gate driver. It generates a counter-compare PWM with a duty shadow register, filters the Hall inputs, and commutates six gate outputs. It adds dead-time insertion, reverse direction, sticky invalid-Hall fault and commutation-period measurement. It sits between the speed/duty controller and the inverter gate pins.

## Interface
- PWM_W, 8, PWM counter and duty width; PWM period = 2^PWM_W cycles
- DT_W, 4, dead-time field width
- HALL_FILT, 3, consecutive synchronized samples required to accept a Hall code (>=1)
- PER_W, 16, commutation-period counter width

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pwm_en  in  1  enable; low = safe state, clears fault
- duty  in  PWM_W  requested duty
- dead_time  in  DT_W  switch turn-on delay in cycles
- dir  in  1  0 forward, 1 reverse
- hall  in  3  {H1,H2,H3}, asynchronous
- pwm_out  out  1  registered PWM
- AP, BP, CP  out  1 each  high-side gates, active-low (1 = off)
- AN, BN, CN  out  1 each  low-side gates, active-high (1 = on)
- fault  out  1  sticky invalid-Hall flag
- comm_period  out  PER_W  cycles between the last two accepted commutations
- comm_stb  out  1  one-cycle pulse when comm_period updates

## Operation
- Reset values: cnt=0, duty_sh=0, pwm_out=0, AP=BP=CP=1, AN=BN=CN=0, fault=0, comm_period=0, comm_stb=0, hall_q=000, per_cnt=0, all dead-time counters 0.
- PWM:
  - While pwm_en=1, cnt increments and wraps 2^PWM_W-1 -> 0.
  - duty_sh loads duty at the edge where cnt wraps to 0, and on the first enabled cycle after pwm_en rises.
  - pwm_out <= (duty_sh > cnt).
  - duty=0 gives constant 0. duty=2^PWM_W-1 gives high for all but one cycle per period.
- pwm_en=0:
  - cnt held at 0 and pwm_out=0.
  - All switches off.
  - Dead-time counters cleared and fault cleared.
  - Hall filter and period counter keep running.
- Hall path:
  - Two-flop synchronizer, then filter.
  - hall_q takes code S once the synchronized value has equalled S for HALL_FILT consecutive edges.
- Phase roles from hall_q, forward (A,B,C; H = high, L = low, F = float):
  - 001: F,L,H
  - 010: L,H,F
  - 100: H,F,L
  - 011: L,F,H
  - 101: H,L,F
  - 110: F,H,L
- dir=1 swaps H and L in every entry.
- hall_q of 000 or 111 means all phases F.
- Switch requests: the phase P switch is requested on when role=H and pwm_out=1. The phase N switch is requested on when role=L and pwm_out=1.
- Dead time, per switch:
  - A request that drops turns the switch off at the next edge.
  - A request that rises turns the switch on only after it has been continuously 1 for dead_time edges, then one output register.
  - dead_time=0 gives a one-cycle register latency only.
  - P and N of the same phase are never on in the same cycle.
- Fault:
  - Set when hall_q becomes 000 or 111 while pwm_en=1.
  - Stays set until pwm_en=0.
  - While fault=1, all switches are off.
- Commutation period:
  - per_cnt increments every cycle and saturates at 2^PER_W-1.
  - An accepted commutation is hall_q changing to a valid code different from its previous value.
  - On each accepted commutation: comm_period <= per_cnt, per_cnt <= 1, comm_stb=1 for one cycle.
  - This runs regardless of pwm_en.

## Timing
- Hall pin change to hall_q update: 2+HALL_FILT edges.
- hall_q to a switch turning off: 1 edge.
- hall_q to a switch turning on: 1+dead_time edges, provided pwm_out=1 throughout.
- pwm_out to gate: 1 edge, plus dead_time on the rising edge of the gate.
- A duty write mid-period has no effect until cnt wraps.
- A Hall glitch shorter than HALL_FILT synchronized cycles is ignored.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronously). Release is synchronous to clk.
- A simultaneous wrap and pwm_en fall: pwm_en=0 wins.

## Test plan
- PWM_W=8, duty=64, pwm_en=1, hall=001, dead_time=0 -> pwm_out high 64 of every 256 cycles. CP low and BN high for 64 cycles each period. AP=1 and AN=0 always.
- Sweep forward 001->011->010->110->100->101 with 1000-cycle dwell -> roles match the table. From the second step on, comm_stb pulses and comm_period=1000. dir=1 reproduces the sequence with H and L swapped.
- dead_time=5, duty=255, hall changes 001->101 -> CP off 1 edge after hall_q changes. AP on no earlier than 6 edges after hall_q changes. No cycle has xP=0 and xN=1 on the same phase.
- Hall pulse to 011 lasting 2 synchronized cycles with HALL_FILT=3 -> hall_q, gates and comm_stb unchanged.
- hall=111 for 10 cycles, pwm_en=1 -> fault=1 and all switches off. Hall returns valid -> fault stays 1. pwm_en=0 for one cycle -> fault=0.
- Change duty 64->200 at cnt=100, then assert rst_n=0 mid-period -> new duty takes effect only after the wrap. On reset, all outputs immediately return to their reset values.
